// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock controller and its neighbours.
//   aclk_state_t : controller FSM states
//   aclk_out_t   : controller strobe/select bundle
//   ACLK_NOKEY   : keypad code for "no key pressed" (also used by LCD driver / key register)
//   is_digit     : true for keypad codes 0..9
//   state_outputs: Moore output decode of an FSM state
package aclk_pkg;

    localparam logic [3:0] ACLK_NOKEY = 4'hA;

    typedef enum logic [2:0] {
        StShowTime,
        StShowAlarm,
        StKeyStored,
        StKeyWaited,
        StKeyEntry,
        StSetAlarmTime,
        StSetCurrentTime
    } aclk_state_t;

    typedef struct packed {
        logic show_a;
        logic show_new_time;
        logic shift;
        logic load_new_a;
        logic load_new_c;
    } aclk_out_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // show_a and show_new_time are mutually exclusive in every state.
    function automatic aclk_out_t state_outputs(input aclk_state_t st);
        aclk_out_t o;
        o = '0;
        unique case (st)
            StShowAlarm:      o.show_a = 1'b1;
            StKeyStored:      begin o.shift = 1'b1;      o.show_new_time = 1'b1; end
            StKeyWaited:      o.show_new_time = 1'b1;
            StKeyEntry:       o.show_new_time = 1'b1;
            StSetAlarmTime:   begin o.load_new_a = 1'b1; o.show_new_time = 1'b1; end
            StSetCurrentTime: begin o.load_new_c = 1'b1; o.show_new_time = 1'b1; end
            default:          o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aclk_controller_if.sv
// Keypad/button inputs and LCD/register strobes of the alarm-clock controller.
//   master : stimulus side (drives buttons, key, one_second; observes strobes)
//   slave  : the controller
interface aclk_controller_if;

    logic       one_second;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key;
    logic       show_a;
    logic       show_new_time;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;

    modport master (
        output one_second, alarm_button, time_button, key,
        input  show_a, show_new_time, shift, load_new_a, load_new_c
    );

    modport slave (
        input  one_second, alarm_button, time_button, key,
        output show_a, show_new_time, shift, load_new_a, load_new_c
    );

endinterface

// File: rtl/aclk_timeout_cnt.sv
// Inactivity timer for key entry.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : hold count at zero
//   tick         : one-second tick, advances the count
//   expired      : tick arriving while count == TIMEOUT_SECS-1
module aclk_timeout_cnt #(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_SECS);

    logic [CntW-1:0] count_q;

    // No saturation: expiry always leaves the counting states, which clears.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = tick && (count_q == CntW'(TIMEOUT_SECS - 1));

endmodule

// File: rtl/aclk_controller.sv
// Central FSM of the alarm clock. Selects the LCD digit source and issues the
// key-register shift and alarm/time load strobes.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : one_second, alarm_button, time_button, key in;
//                  show_a, show_new_time, shift, load_new_a, load_new_c out
// Macro ACLK_CTRL_TIMEOUT_EN enables the inactivity timeout during key entry;
// without it entry is left only by buttons or keys and one_second is ignored.
import aclk_pkg::*;

module aclk_controller #(
    parameter int unsigned TIMEOUT_SECS = 10,
    parameter logic [3:0]  NOKEY        = ACLK_NOKEY
) (
    input logic               clock,
    input logic               reset,
    aclk_controller_if.slave  bus
);

    aclk_state_t state_q, state_d;
    aclk_out_t   out_q;
    logic        timeout;
    logic        key_digit;
    logic        key_none;

    // Codes B..F behave exactly like NOKEY.
    assign key_digit = is_digit(bus.key) && (bus.key != NOKEY);
    assign key_none  = !key_digit;

`ifdef ACLK_CTRL_TIMEOUT_EN
    logic cnt_clear;
    assign cnt_clear = !(state_q inside {StKeyWaited, StKeyEntry});

    aclk_timeout_cnt #(
        .TIMEOUT_SECS (TIMEOUT_SECS)
    ) u_timeout_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .tick    (bus.one_second),
        .expired (timeout)
    );
`else
    localparam int unsigned unused_timeout_secs = TIMEOUT_SECS;
    logic unused_one_second;
    assign unused_one_second = bus.one_second;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StShowTime: begin
                if (bus.alarm_button) state_d = StShowAlarm;
                else if (key_digit)   state_d = StKeyStored;
            end
            StShowAlarm: begin
                if (!bus.alarm_button) state_d = StShowTime;
            end
            StKeyStored: state_d = StKeyWaited;
            StKeyWaited: begin
                if (timeout)       state_d = StShowTime;
                else if (key_none) state_d = StKeyEntry;
            end
            StKeyEntry: begin
                if (bus.alarm_button)     state_d = StSetAlarmTime;
                else if (bus.time_button) state_d = StSetCurrentTime;
                else if (key_digit)       state_d = StKeyStored;
                else if (timeout)         state_d = StShowTime;
            end
            StSetAlarmTime:   state_d = StShowTime;
            StSetCurrentTime: state_d = StShowTime;
            default:          state_d = StShowTime;
        endcase
    end

    // Outputs registered alongside the state, so they always equal the
    // decode of state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StShowTime;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= state_outputs(state_d);
        end
    end

    assign bus.show_a        = out_q.show_a;
    assign bus.show_new_time = out_q.show_new_time;
    assign bus.shift         = out_q.shift;
    assign bus.load_new_a    = out_q.load_new_a;
    assign bus.load_new_c    = out_q.load_new_c;

endmodule
